// File: rtl/riscv_mem_pkg.sv
// Shared types for the unified memory port: FSM encodings, owners, widths.
package riscv_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUSY_IF = 2'b01,
        BUSY_DM = 2'b10
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    function automatic state_t busy_state(input owner_t own);
        return (own == OWN_DM) ? BUSY_DM : BUSY_IF;
    endfunction

endpackage

// File: rtl/mem_timeout_watchdog.sv
// Busy-cycle counter for the memory port; flags expiry on busy cycle TIMEOUT.
module mem_timeout_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic busy,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // cnt holds the number of busy cycles already spent; idle clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!busy) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = busy && (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// IF/MEM arbiter for the single-ported unified memory.
// Optional busy-state abort is built in when MEM_TIMEOUT_EN is defined.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FAIR_LIMIT = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    output logic              if_err,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              dm_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam int FW = $clog2(FAIR_LIMIT + 1);
    localparam logic [FW-1:0] FAIR_MAX = FW'(FAIR_LIMIT);

    state_t            state;
    state_t            state_nx;
    logic [FW-1:0]     fair_cnt;
    logic [FW-1:0]     fair_nx;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_we;
    logic              grant_dm;
    logic              grant_if;
    logic              fair_full;
    logic              expire;
    logic              done;

    if (FAIR_LIMIT < 1 || TIMEOUT < 1) begin : g_bad_cfg
        $error("mem_port_arbiter: FAIR_LIMIT and TIMEOUT must be >= 1");
    end

`ifdef MEM_TIMEOUT_EN
    mem_timeout_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .busy    (state != IDLE),
        .expired (expire)
    );
`else
    assign expire = 1'b0;
`endif

    assign fair_full = (fair_cnt == FAIR_MAX);
    assign done      = mem_ack | expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            fair_cnt  <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
        end else begin
            state    <= state_nx;
            fair_cnt <= fair_nx;
            if (grant_dm) begin
                lat_addr  <= dm_addr;
                lat_wdata <= dm_wdata;
                lat_we    <= dm_we;
            end else if (grant_if) begin
                lat_addr <= if_addr;
                lat_we   <= 1'b0;
            end
        end
    end

    // DM wins ties until FAIR_LIMIT grants have starved a waiting fetch
    always_comb begin
        state_nx = state;
        fair_nx  = fair_cnt;
        grant_dm = 1'b0;
        grant_if = 1'b0;
        unique case (state)
            IDLE: begin
                if (dm_req && (!fair_full || !if_req)) begin
                    grant_dm = 1'b1;
                    state_nx = busy_state(OWN_DM);
                    fair_nx  = if_req ? fair_cnt + 1'b1 : '0;
                end else if (if_req) begin
                    grant_if = 1'b1;
                    state_nx = busy_state(OWN_IF);
                    fair_nx  = '0;
                end else begin
                    fair_nx = '0;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (done) state_nx = IDLE;
                if (!if_req) fair_nx = '0;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        if_ready = 1'b0;
        if_err   = 1'b0;
        if_rdata = '0;
        dm_ready = 1'b0;
        dm_err   = 1'b0;
        dm_rdata = '0;
        unique case (state)
            BUSY_IF: begin
                mem_req  = 1'b1;
                if_ready = done;
                if_err   = expire & ~mem_ack;
                if (mem_ack) if_rdata = mem_rdata;
            end
            BUSY_DM: begin
                mem_req  = 1'b1;
                mem_we   = lat_we;
                dm_ready = done;
                dm_err   = expire & ~mem_ack;
                if (mem_ack) dm_rdata = mem_rdata;
            end
            default: ;
        endcase
        stall_if  = if_req & ~if_ready;
        stall_mem = dm_req & ~dm_ready;
    end

    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction model.
// Build with MEM_TIMEOUT_EN defined to also exercise the abort path.
module tb_mem_port_arbiter;

    localparam int FL = 2;
    localparam int TO = 8;
`ifdef MEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
    localparam int ACK_MAX = 10;
`else
    localparam bit TO_EN = 1'b0;
    localparam int ACK_MAX = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        if_err;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        dm_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_if;
    logic        stall_mem;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .FAIR_LIMIT(FL), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .if_err(if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .dm_ready(dm_ready), .dm_err(dm_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // transaction model: owner 0 none, 1 fetch, 2 data; age = busy cycle number
    int          m_own;
    int          m_age;
    int          m_cnt;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    bit          m_we;
    int          grants[$];
    int          ack_delay;
    bit          rand_ack;
    bit          use_fix;
    logic [31:0] rd_fix;
    bit          e_if_rdy;
    bit          e_dm_rdy;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_own = 0; m_age = 0; m_cnt = 0;
        m_addr = '0; m_wdata = '0; m_we = 1'b0;
    endtask

    task automatic drive_mem(input bit noise);
        if (m_own != 0) mem_ack = (m_age == ack_delay + 1);
        else mem_ack = noise && ($urandom_range(0, 9) == 0);
        mem_rdata = use_fix ? rd_fix : $urandom;
    endtask

    task automatic tick();
        bit busy, to, fin, e_if, e_dm;
        logic [31:0] e_rd;
        busy = (m_own != 0);
        to   = TO_EN && busy && (m_age == TO);
        fin  = busy && (mem_ack || to);
        e_if = fin && (m_own == 1);
        e_dm = fin && (m_own == 2);
        e_rd = mem_ack ? mem_rdata : 32'h0;
        @(negedge clk);
        check("mem_req", mem_req, busy);
        check("mem_we", mem_we, busy && m_we);
        if (busy) begin
            check("mem_addr", mem_addr, m_addr);
            check("mem_wdata", mem_wdata, m_wdata);
        end
        check("if_ready", if_ready, e_if);
        check("if_err", if_err, e_if && !mem_ack);
        check("if_rdata", if_rdata, e_if ? e_rd : 32'h0);
        check("dm_ready", dm_ready, e_dm);
        check("dm_err", dm_err, e_dm && !mem_ack);
        check("dm_rdata", dm_rdata, e_dm ? e_rd : 32'h0);
        check("stall_if", stall_if, if_req && !e_if);
        check("stall_mem", stall_mem, dm_req && !e_dm);
        e_if_rdy = e_if;
        e_dm_rdy = e_dm;
        if (busy) begin
            if (fin) m_own = 0;
            else m_age++;
            if (!if_req) m_cnt = 0;
        end else if (dm_req && (m_cnt < FL || !if_req)) begin
            m_own = 2; m_age = 1;
            m_addr = dm_addr; m_wdata = dm_wdata; m_we = dm_we;
            m_cnt = if_req ? m_cnt + 1 : 0;
            grants.push_back(2);
            if (rand_ack) ack_delay = $urandom_range(0, ACK_MAX);
        end else if (if_req) begin
            m_own = 1; m_age = 1;
            m_addr = if_addr; m_we = 1'b0; m_cnt = 0;
            grants.push_back(1);
            if (rand_ack) ack_delay = $urandom_range(0, ACK_MAX);
        end else begin
            m_cnt = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input bit want_dm, input int lim, output int n);
        n = 0;
        do begin
            drive_mem(1'b0);
            tick();
            n++;
        end while (!(want_dm ? e_dm_rdy : e_if_rdy) && n < lim);
        if (!(want_dm ? e_dm_rdy : e_if_rdy)) check("wait_bound", n, 0);
    endtask

    task automatic idle_tick();
        if_req = 1'b0;
        dm_req = 1'b0;
        drive_mem(1'b0);
        tick();
    endtask

    int n;
    int g0;
    logic [11:0] pat;

    initial begin
        rst_n = 1'b0;
        if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0;
        dm_addr = 0; dm_wdata = 0; mem_rdata = 0; mem_ack = 0;
        rand_ack = 0; use_fix = 0; rd_fix = 0; ack_delay = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle_tick();

        // fetch only, ack three cycles after mem_req rises
        use_fix = 1; rd_fix = 32'h0050_0093; ack_delay = 3;
        if_req = 1; if_addr = 32'h0;
        wait_rdy(1'b0, 20, n);
        check("if_only_cycles", n, 5);
        use_fix = 0;
        idle_tick();

        // simultaneous fetch and load: data first
        ack_delay = 1; g0 = grants.size();
        if_req = 1; if_addr = 32'h8;
        dm_req = 1; dm_we = 0; dm_addr = 32'h100;
        wait_rdy(1'b1, 20, n);
        dm_req = 0;
        wait_rdy(1'b0, 20, n);
        if_req = 0;
        check("tie_first", grants[g0], 2);
        check("tie_second", grants[g0+1], 1);
        idle_tick();

        // store with immediate ack
        ack_delay = 0; g0 = grants.size();
        dm_req = 1; dm_we = 1; dm_addr = 32'h104; dm_wdata = 32'hDEAD_BEEF;
        wait_rdy(1'b1, 10, n);
        check("sw_cycles", n, 2);
        idle_tick();
        check("sw_grants", grants.size() - g0, 1);

        // fairness with a held fetch and continuously re-issued loads
        ack_delay = 0; g0 = grants.size();
        if_req = 1; if_addr = 32'h40;
        dm_req = 1; dm_we = 0; dm_addr = 32'h200;
        for (int i = 0; i < 60 && grants.size() < g0 + 6; i++) begin
            drive_mem(1'b0);
            tick();
            if (e_dm_rdy) dm_addr = dm_addr + 32'h4;
            if (e_if_rdy) if_addr = if_addr + 32'h4;
        end
        pat = '0;
        for (int i = 0; i < 6; i++)
            if (g0 + i < grants.size()) pat = {pat[9:0], 2'(grants[g0+i])};
        check("fair_order", pat, 12'b10_10_01_10_10_01);
        idle_tick();
        idle_tick();

        // reset in the middle of a data transaction
        ack_delay = 10;
        dm_req = 1; dm_we = 0; dm_addr = 32'h300;
        drive_mem(1'b0); tick();
        drive_mem(1'b0); tick();
        mem_ack = 1;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_mem_req", mem_req, 1'b0);
        check("rst_mid_dm_ready", dm_ready, 1'b0);
        check("rst_mid_dm_err", dm_err, 1'b0);
        dm_req = 0; mem_ack = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) idle_tick();

`ifdef MEM_TIMEOUT_EN
        // no ack: abort on busy cycle TO; then ack exactly on that cycle
        ack_delay = 50;
        dm_req = 1; dm_we = 0; dm_addr = 32'h400;
        wait_rdy(1'b1, 30, n);
        check("to_cycles", n, TO + 1);
        idle_tick();
        ack_delay = TO - 1;
        dm_req = 1; dm_addr = 32'h404;
        wait_rdy(1'b1, 30, n);
        check("to_tie_cycles", n, TO + 1);
        idle_tick();
`endif

        // randomized traffic
        rand_ack = 1;
        for (int i = 0; i < 1500; i++) begin
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req = 1; dm_we = 1'($urandom_range(0, 1));
                dm_addr = $urandom & 32'hFFFF_FFFC; dm_wdata = $urandom;
            end
            drive_mem(1'b1);
            tick();
            if (e_if_rdy) begin
                if ($urandom_range(0, 1) == 1) if_addr = $urandom & 32'hFFFF_FFFC;
                else if_req = 0;
            end
            if (e_dm_rdy) begin
                if ($urandom_range(0, 1) == 1) begin
                    dm_we = 1'($urandom_range(0, 1));
                    dm_addr = $urandom & 32'hFFFF_FFFC; dm_wdata = $urandom;
                end else begin
                    dm_req = 0;
                end
            end
        end
        rand_ack = 0;
        ack_delay = 0;
        for (int i = 0; i < 40 && m_own != 0; i++) idle_tick();
        idle_tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
